// File: rtl/key_sw_debouncer.sv
// key_sw_debouncer
//
// Conditions the raw board push-buttons and slide switches before they
// reach the lab logic. Each bit goes through a two-flop synchroniser and
// then a per-bit stability counter. The debounced level flips only after
// the synchronised bit has differed from it for stable_cycles consecutive
// edges. On the cycle after a flip, a one-cycle pulse reports the edge.
//
// Ports
//   clk          : system clock; all state updates on the rising edge
//   rst          : synchronous, active-low reset
//   key_raw      : raw asynchronous push-buttons (w_key bits)
//   sw_raw       : raw asynchronous slide switches (w_sw bits)
//   key_db       : debounced key level, 1 = pressed
//   sw_db        : debounced switch level
//   key_pressed  : one-cycle pulse when a key_db bit rises
//   key_released : one-cycle pulse when a key_db bit falls
//   sw_changed   : one-cycle pulse on any sw_db bit transition
//
// Every output comes straight from a flop, or from an AND of two flops.
// No input reaches an output without passing through a flop.

module key_sw_debouncer #(
    parameter int clk_mhz        = 50,
    parameter int w_key          = 4,
    parameter int w_sw           = 8,
    parameter int debounce_ms    = 10,
    parameter int stable_cycles  = clk_mhz * 1000 * debounce_ms,
    parameter bit key_active_low = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [w_key-1:0]  key_raw,
    input  logic [w_sw-1:0]   sw_raw,
    output logic [w_key-1:0]  key_db,
    output logic [w_sw-1:0]   sw_db,
    output logic [w_key-1:0]  key_pressed,
    output logic [w_key-1:0]  key_released,
    output logic [w_sw-1:0]   sw_changed
);

    // Keys and switches share the same per-bit machinery.
    // Switches occupy the upper bits of the combined vector.
    localparam int w  = w_key + w_sw;
    localparam int cw = $clog2(stable_cycles + 1);

    localparam logic [cw-1:0] cnt_last = cw'(stable_cycles - 1);
    localparam logic [cw-1:0] cnt_one  = cw'(1);

    logic [w_key-1:0] key_n;
    logic [w-1:0]     in_n;
    logic [w-1:0]     sync1;
    logic [w-1:0]     sync2;
    logic [w-1:0]     db;
    logic [w-1:0]     pulse;
    logic [cw-1:0]    cnt [w];

    // Invert the keys so that a pressed key is 1. After inversion, the
    // all-zero reset value of the synchroniser matches the idle inputs.
    assign key_n = key_active_low ? ~key_raw : key_raw;
    assign in_n  = {sw_raw, key_n};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            pulse <= '0;
            for (int i = 0; i < w; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_n;
            sync2 <= sync1;
            for (int i = 0; i < w; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == db[i]) begin
                    // Any agreement, even a single cycle, restarts the window.
                    cnt[i] <= '0;
                end else if (cnt[i] == cnt_last) begin
                    // This edge is the stable_cycles-th differing edge in a row.
                    db[i]    <= sync2[i];
                    cnt[i]   <= '0;
                    pulse[i] <= 1'b1;
                end else begin
                    // cnt never exceeds cnt_last, so it cannot wrap.
                    cnt[i] <= cnt[i] + cnt_one;
                end
            end
        end
    end

    // pulse marks the cycle after a flip, and db already holds the new level.
    // So the flip direction follows from db.
    assign key_db       = db[w_key-1:0];
    assign sw_db        = db[w-1:w_key];
    assign key_pressed  = pulse[w_key-1:0] & db[w_key-1:0];
    assign key_released = pulse[w_key-1:0] & ~db[w_key-1:0];
    assign sw_changed   = pulse[w-1:w_key];

endmodule

// File: tb/tb_key_sw_debouncer.sv
module tb_key_sw_debouncer;

    localparam int SC = 4;

    logic       clk;
    logic       rst;
    logic [3:0] key_raw;
    logic [7:0] sw_raw;
    logic [3:0] key_db;
    logic [7:0] sw_db;
    logic [3:0] key_pressed;
    logic [3:0] key_released;
    logic [7:0] sw_changed;

    int total = 0;
    int bad   = 0;

    key_sw_debouncer #(
        .w_key         (4),
        .w_sw          (8),
        .stable_cycles (SC),
        .key_active_low(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .sw_raw      (sw_raw),
        .key_db      (key_db),
        .sw_db       (sw_db),
        .key_pressed (key_pressed),
        .key_released(key_released),
        .sw_changed  (sw_changed)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack all outputs as {key_db, sw_db, key_pressed, key_released, sw_changed}.
    function automatic logic [27:0] mk(logic [3:0] kdb, logic [7:0] sdb,
                                       logic [3:0] kp, logic [3:0] kr,
                                       logic [7:0] sc);
        return {kdb, sdb, kp, kr, sc};
    endfunction

    logic [27:0] outs;
    assign outs = {key_db, sw_db, key_pressed, key_released, sw_changed};

    // Reference model, used for the random soak.
    // It counts consecutive edges on which the synchronised bit differs
    // from the debounced level. The level flips on the SC-th such edge.
    logic [11:0] m_s1, m_s2, m_db, m_p;
    int          m_run [12];

    always @(posedge clk) begin
        if (!rst) begin
            m_s1 <= '0;
            m_s2 <= '0;
            m_db <= '0;
            m_p  <= '0;
            for (int i = 0; i < 12; i++) m_run[i] <= 0;
        end else begin
            m_s1 <= {sw_raw, ~key_raw};
            m_s2 <= m_s1;
            for (int i = 0; i < 12; i++) begin
                if (m_s2[i] !== m_db[i]) begin
                    if (m_run[i] + 1 >= SC) begin
                        m_db[i]  <= m_s2[i];
                        m_p[i]   <= 1'b1;
                        m_run[i] <= 0;
                    end else begin
                        m_p[i]   <= 1'b0;
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_p[i]   <= 1'b0;
                    m_run[i] <= 0;
                end
            end
        end
    end

    logic [27:0] m_outs;
    assign m_outs = mk(m_db[3:0], m_db[11:4], m_p[3:0] & m_db[3:0],
                       m_p[3:0] & ~m_db[3:0], m_p[11:4]);

    // driver tasks
    // Each tick ends 1 time unit after a rising edge. Samples and new
    // inputs are both taken at that point, away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%07h exp=%07h", tag, got, exp);
        end
    endtask

    initial begin
        rst     = 1'b0;
        key_raw = 4'hF;
        sw_raw  = 8'h00;

        // Reset and idle
        tick(3);
        chk("reset", outs, 28'h0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle", outs, 28'h0);
        end

        // Clean press on key[0]. Captured at edge N and flips at N+5.
        key_raw = 4'b1110;
        tick(5);
        chk("press_wait", outs, 28'h0);
        tick(1);
        chk("press_pulse", outs, mk(4'h1, 8'h00, 4'h1, 4'h0, 8'h00));
        tick(1);
        chk("press_hold", outs, mk(4'h1, 8'h00, 4'h0, 4'h0, 8'h00));
        tick(3);
        chk("press_hold2", outs, mk(4'h1, 8'h00, 4'h0, 4'h0, 8'h00));
        key_raw = 4'hF;
        tick(5);
        chk("release_wait", outs, mk(4'h1, 8'h00, 4'h0, 4'h0, 8'h00));
        tick(1);
        chk("release_pulse", outs, mk(4'h0, 8'h00, 4'h0, 4'h1, 8'h00));
        tick(1);
        chk("release_idle", outs, 28'h0);

        // Bounce on key[2]: low 3, high 1, low 2, then high. Nothing reaches the outputs.
        key_raw = 4'b1011;
        for (int i = 0; i < 3; i++) begin tick(1); chk("bounce_a", outs, 28'h0); end
        key_raw = 4'hF;
        tick(1); chk("bounce_b", outs, 28'h0);
        key_raw = 4'b1011;
        for (int i = 0; i < 2; i++) begin tick(1); chk("bounce_c", outs, 28'h0); end
        key_raw = 4'hF;
        for (int i = 0; i < 8; i++) begin tick(1); chk("bounce_d", outs, 28'h0); end
        // Then a long hold produces exactly one pulse.
        key_raw = 4'b1011;
        tick(5);
        chk("hold2_wait", outs, 28'h0);
        tick(1);
        chk("hold2_pulse", outs, mk(4'h4, 8'h00, 4'h4, 4'h0, 8'h00));
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("hold2_after", outs, mk(4'h4, 8'h00, 4'h0, 4'h0, 8'h00));
        end
        key_raw = 4'hF;
        tick(6);
        chk("hold2_release", outs, mk(4'h0, 8'h00, 4'h0, 4'h4, 8'h00));
        tick(1);
        chk("hold2_idle", outs, 28'h0);

        // Simultaneous key[1] press and sw change to 8'h81.
        key_raw = 4'b1101;
        sw_raw  = 8'h81;
        tick(5);
        chk("simul_wait", outs, 28'h0);
        tick(1);
        chk("simul_pulse", outs, mk(4'h2, 8'h81, 4'h2, 4'h0, 8'h81));
        tick(1);
        chk("simul_hold", outs, mk(4'h2, 8'h81, 4'h0, 4'h0, 8'h00));
        key_raw = 4'hF;
        tick(6);
        chk("simul_release", outs, mk(4'h0, 8'h81, 4'h0, 4'h2, 8'h00));
        tick(1);
        chk("simul_idle", outs, mk(4'h0, 8'h81, 4'h0, 4'h0, 8'h00));

        // Reset mid-count: press key[3]. The counter reaches 2 after 4 edges.
        key_raw = 4'b0111;
        tick(4);
        chk("midcnt_pre", outs, mk(4'h0, 8'h81, 4'h0, 4'h0, 8'h00));
        rst = 1'b0;
        tick(1);
        chk("midcnt_reset", outs, 28'h0);
        rst = 1'b1;
        // The first edge with rst==1 is M. Key and switches both flip at M+5.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("midcnt_wait", outs, 28'h0);
        end
        tick(1);
        chk("midcnt_pulse", outs, mk(4'h8, 8'h81, 4'h8, 4'h0, 8'h81));
        tick(1);
        chk("midcnt_hold", outs, mk(4'h8, 8'h81, 4'h0, 4'h0, 8'h00));

        // Random soak, updating every 10 cycles and checked on every cycle.
        for (int u = 0; u < 12; u++) begin
            key_raw = 4'($urandom_range(0, 15));
            sw_raw  = 8'($urandom_range(0, 255));
            for (int c = 0; c < 10; c++) begin
                tick(1);
                chk("soak10", outs, m_outs);
            end
        end
        // Fast updates every 3 cycles, to exercise glitch rejection.
        for (int u = 0; u < 10; u++) begin
            key_raw = 4'($urandom_range(0, 15));
            sw_raw  = 8'($urandom_range(0, 255));
            for (int c = 0; c < 3; c++) begin
                tick(1);
                chk("soak3", outs, m_outs);
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("soak_settle", outs, m_outs);
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
